// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg
//   Shared definitions for the counter scheduler:
//     state_e  - FSM encoding (IDLE/RUN/DONE; 2'd3 is unused)
//     rr_pick  - round-robin winner search starting at a pointer
package counter_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns the first index i with req[i]=1, searching ptr, ptr+1, ... mod n.
  // The loop runs downward so the smallest distance from ptr wins last.
  // Returns ptr when req is empty; callers only use the result when |req.
  // n must be in 2..32 and ptr < n.
  function automatic int rr_pick(input logic [31:0] req, input int n, input int ptr);
    int pick;
    int idx;
    pick = ptr;
    for (int k = 31; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[4:0]]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_sched_core.sv
// counter_core
//   Shared W-bit up-counter driven by the scheduler.
//   Ports:
//     clk - clock, rising edge
//     rst - synchronous active-high reset (cnt -> 0)
//     clr - synchronous clear, priority over en
//     en  - increment enable
//     cnt - current count
module counter_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else if (en)    cnt_q <= cnt_q + 1'b1;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/counter_sched.sv
// counter_sched
//   Round-robin scheduler sharing one W-bit up-counter between N requesters.
//   A winner is granted, the counter runs 0..limit, done pulses to the owner
//   for one cycle, then the scheduler re-arbitrates from owner+1.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     req  - per-requester run request (level)
//     len  - per-requester run length, slice i = len[i*W +: W]
//     gnt  - one-hot owner of the counter, 0 when idle (registered)
//     done - one-cycle completion pulse to the owner (registered)
//     busy - high in RUN or DONE
//     cnt  - current counter value
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           busy,
  output logic [W-1:0]   cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  done_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] owner_q;
  logic [W-1:0]  limit_q;

  logic [IW-1:0] win_d;
  logic [IW-1:0] rr_ptr_d;
  logic          start;
  logic          clr;
  logic          en;
  logic [W-1:0]  cnt_w;

  assign win_d    = IW'(rr_pick(32'(req), N, int'(rr_ptr_q)));
  assign rr_ptr_d = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign start    = (state_q == ST_IDLE) && (|req);

  // Counter is cleared on the grant edge and only advances while below limit,
  // so it stops exactly at limit and can never wrap.
  assign clr = start;
  assign en  = (state_q == ST_RUN) && (cnt_w != limit_q);

  counter_core #(.W(W)) u_core (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .cnt (cnt_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q   <= N'(1) << win_d;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_w == limit_q) begin
            done_q  <= N'(1) << owner_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt_q    <= '0;
          rr_ptr_q <= rr_ptr_d;
          state_q  <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Owner and run length are captured once at grant; later req/len changes
  // are ignored until the run finishes.
  always_ff @(posedge clk) begin
    if (start) begin
      owner_q <= win_d;
      limit_q <= len[int'(win_d)*W +: W];
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);
  assign cnt  = cnt_w;

endmodule
